// File: rtl/rx_ts_pkg.sv
// rtl/rx_ts_pkg.sv - Training-set symbol constants and shared types for the RX TS decoder
package rx_ts_pkg;

  localparam logic [7:0] COM        = 8'hBC;
  localparam logic [7:0] PAD        = 8'hF7;
  localparam logic [7:0] TS1_ID     = 8'h4A;
  localparam logic [7:0] TS2_ID     = 8'h45;
  localparam logic [7:0] TS1_ID_INV = 8'hB5;
  localparam logic [7:0] TS2_ID_INV = 8'hBA;

  // Key for the consecutive-set compare: type, pad flags, symbols 1-5
  localparam int TS_KEY_W = 43;

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_HDR  = 2'd1,
    ST_ID   = 2'd2
  } rx_state_e;

  typedef enum logic {
    TS_TYPE_TS1 = 1'b0,
    TS_TYPE_TS2 = 1'b1
  } ts_type_e;

endpackage

// File: rtl/rx_ts_decoder_if.sv
// rtl/rx_ts_decoder_if.sv - PIPE receive symbol stream into the TS decoder
interface rx_ts_decoder_if;
  logic [7:0] RxData;
  logic       RxDataK;
  logic       RxValid;

  modport master (output RxData, output RxDataK, output RxValid);
  modport slave  (input  RxData, input  RxDataK, input  RxValid);
endinterface

// File: rtl/ts_consec_counter.sv
// rtl/ts_consec_counter.sv - Counts consecutive identical good training sets against a stored reference
module ts_consec_counter
  import rx_ts_pkg::*;
(
  input  logic                pclk,
  input  logic                reset_n,
  input  logic                set_done,
  input  logic                set_error,
  input  logic                clear,
  input  logic [TS_KEY_W-1:0] set_key,
  output logic [3:0]          count
);

  logic [TS_KEY_W-1:0] ref_key;
  logic                ref_valid;

  // A clear or error beats a coincident completion and drops the reference
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      count     <= 4'd0;
      ref_key   <= '0;
      ref_valid <= 1'b0;
    end else if (clear || set_error) begin
      count     <= 4'd0;
      ref_valid <= 1'b0;
    end else if (set_done) begin
      if (ref_valid && (set_key == ref_key)) begin
        if (count != 4'd15) count <= count + 4'd1;
      end else begin
        count     <= 4'd1;
        ref_key   <= set_key;
        ref_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rx_ts_decoder.sv
// rtl/rx_ts_decoder.sv - PIPE TS1/TS2 ordered-set decoder with consecutive-set counting
// Optional RX_TS_POLARITY_DETECT_EN accepts inverted TS identifiers and flags polarity_inv.
module rx_ts_decoder
  import rx_ts_pkg::*;
#(
  parameter int CONSEC_TARGET = 8
)(
  input  logic             pclk,
  input  logic             reset_n,
  rx_ts_decoder_if.slave   pipe,
  input  logic             clear_count,
  output logic             ts_valid,
  output logic             ts_type,
  output logic [7:0]       link_num,
  output logic [7:0]       lane_num,
  output logic             link_pad,
  output logic             lane_pad,
  output logic [7:0]       n_fts,
  output logic [7:0]       rate_id,
  output logic [7:0]       train_ctrl,
  output logic [3:0]       consec_count,
  output logic             consec_done,
  output logic             ts_error,
  output logic             polarity_inv
);

  localparam logic [1:0] HUNT = ST_HUNT;
  localparam logic [1:0] HDR  = ST_HDR;
  localparam logic [1:0] ID   = ST_ID;

  logic [1:0] state;
  logic [3:0] sym_idx;
  logic [7:0] link_q, lane_q, nfts_q, rate_q, ctrl_q, id_q;
  logic       link_pad_q, lane_pad_q;
  ts_type_e   type_q;

  logic       is_com, hdr_bad, id_bad, id_ok;
  logic       set_done, set_err;
  ts_type_e   id_type_nxt;
  logic       id_inv_nxt;

  assign is_com = pipe.RxValid && pipe.RxDataK && (pipe.RxData == COM);

  always_comb begin
    id_ok       = 1'b0;
    id_type_nxt = TS_TYPE_TS1;
    id_inv_nxt  = 1'b0;
    if (!pipe.RxDataK) begin
      case (pipe.RxData)
        TS1_ID:     id_ok = 1'b1;
        TS2_ID:     begin id_ok = 1'b1; id_type_nxt = TS_TYPE_TS2; end
`ifdef RX_TS_POLARITY_DETECT_EN
        TS1_ID_INV: begin id_ok = 1'b1; id_inv_nxt = 1'b1; end
        TS2_ID_INV: begin id_ok = 1'b1; id_type_nxt = TS_TYPE_TS2; id_inv_nxt = 1'b1; end
`endif
        default:    id_ok = 1'b0;
      endcase
    end
  end

  // Only link and lane slots may carry PAD; any other K symbol is malformed
  assign hdr_bad = pipe.RxDataK &&
                   !(((sym_idx == 4'd1) || (sym_idx == 4'd2)) && (pipe.RxData == PAD));
  assign id_bad  = (sym_idx == 4'd6) ? !id_ok
                                     : (pipe.RxDataK || (pipe.RxData != id_q));

  assign set_done = pipe.RxValid && (state == ID) && !is_com && !id_bad && (sym_idx == 4'd15);
  assign set_err  = pipe.RxValid &&
                    (((state != HUNT) && is_com) ||
                     ((state == HDR) && hdr_bad) ||
                     ((state == ID)  && id_bad));

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= HUNT;
      sym_idx    <= 4'd0;
      link_q     <= 8'd0;
      lane_q     <= 8'd0;
      nfts_q     <= 8'd0;
      rate_q     <= 8'd0;
      ctrl_q     <= 8'd0;
      id_q       <= 8'd0;
      link_pad_q <= 1'b0;
      lane_pad_q <= 1'b0;
      type_q     <= TS_TYPE_TS1;
    end else if (pipe.RxValid) begin
      case (state)
        HUNT: begin
          if (is_com) begin
            state   <= HDR;
            sym_idx <= 4'd1;
          end
        end
        HDR: begin
          if (is_com) begin
            sym_idx <= 4'd1;
          end else if (hdr_bad) begin
            state   <= HUNT;
            sym_idx <= 4'd0;
          end else begin
            case (sym_idx)
              4'd1:    begin link_q <= pipe.RxData; link_pad_q <= pipe.RxDataK; end
              4'd2:    begin lane_q <= pipe.RxData; lane_pad_q <= pipe.RxDataK; end
              4'd3:    nfts_q <= pipe.RxData;
              4'd4:    rate_q <= pipe.RxData;
              default: ctrl_q <= pipe.RxData;
            endcase
            if (sym_idx == 4'd5) state <= ID;
            sym_idx <= sym_idx + 4'd1;
          end
        end
        ID: begin
          if (is_com) begin
            state   <= HDR;
            sym_idx <= 4'd1;
          end else if (id_bad || (sym_idx == 4'd15)) begin
            state   <= HUNT;
            sym_idx <= 4'd0;
          end else begin
            if (sym_idx == 4'd6) begin
              id_q   <= pipe.RxData;
              type_q <= id_type_nxt;
            end
            sym_idx <= sym_idx + 4'd1;
          end
        end
        default: begin
          state   <= HUNT;
          sym_idx <= 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      ts_valid   <= 1'b0;
      ts_error   <= 1'b0;
      ts_type    <= 1'b0;
      link_num   <= 8'd0;
      lane_num   <= 8'd0;
      link_pad   <= 1'b0;
      lane_pad   <= 1'b0;
      n_fts      <= 8'd0;
      rate_id    <= 8'd0;
      train_ctrl <= 8'd0;
    end else begin
      ts_valid <= set_done;
      ts_error <= set_err;
      if (set_done) begin
        ts_type    <= type_q;
        link_num   <= link_q;
        lane_num   <= lane_q;
        link_pad   <= link_pad_q;
        lane_pad   <= lane_pad_q;
        n_fts      <= nfts_q;
        rate_id    <= rate_q;
        train_ctrl <= ctrl_q;
      end
    end
  end

`ifdef RX_TS_POLARITY_DETECT_EN
  logic inv_q;

  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      inv_q        <= 1'b0;
      polarity_inv <= 1'b0;
    end else begin
      if (pipe.RxValid && (state == ID) && !is_com && (sym_idx == 4'd6) && id_ok)
        inv_q <= id_inv_nxt;
      if (set_done)
        polarity_inv <= inv_q;
    end
  end
`else
  assign polarity_inv = 1'b0;
`endif

  ts_consec_counter u_consec (
    .pclk      (pclk),
    .reset_n   (reset_n),
    .set_done  (set_done),
    .set_error (set_err),
    .clear     (clear_count),
    .set_key   ({type_q, link_pad_q, lane_pad_q, link_q, lane_q, nfts_q, rate_q, ctrl_q}),
    .count     (consec_count)
  );

  assign consec_done = ({28'd0, consec_count} >= CONSEC_TARGET[31:0]);

endmodule

// File: doc/rx_ts_decoder.md
RX_TS_DECODER -- requirements
Module: rx_ts_decoder

Interface
REQ-001 SHALL have parameter CONSEC_TARGET, default 8: number of consecutive identical training sets that asserts consec_done.
REQ-002 SHALL have port pclk, input, 1 bit: sole clock; all logic samples on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port RxData, input, 8 bits: one received symbol per cycle from PIPE.
REQ-005 SHALL have port RxDataK, input, 1 bit: marks RxData as a K symbol.
REQ-006 SHALL have port RxValid, input, 1 bit: symbol qualifier; when low, the state machine holds its state.
REQ-007 SHALL have port clear_count, input, 1 bit: synchronous clear of the consecutive-set counter.
REQ-008 SHALL have port ts_valid, output, 1 bit: one-cycle pulse when a good TS1/TS2 completes.
REQ-009 SHALL have port ts_type, output, 1 bit: 0 = TS1, 1 = TS2.
REQ-010 SHALL have ports link_num and lane_num, outputs, 8 bits each: symbol 1 and symbol 2 of the set.
REQ-011 SHALL have ports link_pad and lane_pad, outputs, 1 bit each: the corresponding symbol was PAD.
REQ-012 SHALL have ports n_fts, rate_id and train_ctrl, outputs, 8 bits each: symbols 3, 4 and 5 of the set.
REQ-013 SHALL have port consec_count, output, 4 bits: consecutive-identical-set count, saturating at 15.
REQ-014 SHALL have port consec_done, output, 1 bit: level, asserted when consec_count >= CONSEC_TARGET.
REQ-015 SHALL have port ts_error, output, 1 bit: one-cycle pulse on a malformed set.
REQ-016 SHALL have port polarity_inv, output, 1 bit: set was received with inverted TS identifiers.

Function
REQ-017 SHALL run an FSM with states HUNT, HDR (symbols 1-5) and ID (symbols 6-15); a symbol index advances only when RxValid=1.
REQ-018 HUNT SHALL go to HDR on COM (8'hBC, K=1) and SHALL discard all other symbols silently.
REQ-019 HDR SHALL capture symbols 1-5; symbols 1 and 2 are accepted as PAD (8'hF7, K=1) or data; any other K symbol SHALL raise ts_error.
REQ-020 Symbol 6 SHALL fix the set type: 8'h4A = TS1, 8'h45 = TS2; symbols 7-15 SHALL equal symbol 6, all with K=0.
REQ-021 Any mismatch in the ID field SHALL pulse ts_error and return the FSM to HUNT.
REQ-022 COM received while in HDR or ID SHALL pulse ts_error and restart at HDR, symbol index 1.
REQ-023 ts_valid and all field outputs SHALL update in the cycle after symbol 15 is accepted (latency 1); field outputs hold their values between sets.
REQ-024 Counter rules:
- first good set -> consec_count = 1;
- set identical to the previous good set (type plus symbols 1-5) -> consec_count + 1, saturating at 15;
- differing good set -> consec_count = 1, and that set becomes the new reference;
- ts_error -> consec_count = 0 and the reference is invalidated.
REQ-025 When clear_count coincides with a set completion, clear SHALL win: consec_count = 0 and the reference is invalidated; ts_valid still pulses.
REQ-026 RxValid low mid-set SHALL freeze the FSM without raising an error.

Reset
REQ-027 On reset_n=0 the FSM SHALL go to HUNT and all outputs, the counter and the reference SHALL be 0; the reference is invalid.
REQ-028 Reset asserted mid-set SHALL abort the set without pulsing ts_error.

Configuration
REQ-029 Macro RX_TS_POLARITY_DETECT_EN:
- defined: ID 8'hB5 (inverted TS1) or 8'hBA (inverted TS2) is accepted as that type, and polarity_inv is set with ts_valid;
- undefined: inverted IDs are errors per REQ-021, and polarity_inv is tied to 0.

Structure
REQ-030 Package rx_ts_pkg SHALL hold:
- COM, PAD, TS1_ID, TS2_ID and the inverted-ID constants;
- the FSM state enum;
- the ts_type enum.
REQ-031 The counter and reference compare SHALL be the sub-module ts_consec_counter; everything else stays in rx_ts_decoder.

Verification
REQ-032 Eight identical TS1 sets (link 8'h00, lane PAD, rate 8'h02) -> eight ts_valid pulses, consec_count 1..8, consec_done high after the 8th.
REQ-033 Three TS1 sets then one TS2 -> consec_count 3, then 1; ts_type=1.
REQ-034 COM injected at symbol 9 -> ts_error pulse; the following full set decodes with consec_count=1.
REQ-035 RxValid low for 5 cycles at symbol 4 -> no error; fields are correct when the set completes.
REQ-036 clear_count asserted in the completion cycle of the 4th identical set -> consec_count=0; the next set gives 1.
REQ-037 With RX_TS_POLARITY_DETECT_EN, an ID of 8'hBA -> ts_type=1 and polarity_inv=1; without the macro -> ts_error.
